// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says pad encoder/decoder pair.
package simon_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned KEY_W    = 4;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [KEY_W-1:0]    key_idx_t;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    HELD     = 2'd2
  } btn_state_t;

  // Bit i of the code is the OR of every key whose index has bit i set; exact only for one-hot input.
  function automatic key_idx_t encode(input key_vec_t v);
    key_idx_t c;
    c = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      for (int i = 0; i < int'(KEY_W); i++) begin
        if (((k >> i) & 1) == 1) c[i] = c[i] | v[k];
      end
    end
    return c;
  endfunction

  function automatic logic is_onehot(input key_vec_t v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/vec_debounce.sv
// Two-flop synchroniser plus a single shared debounce counter for a whole button vector.
// primed rises the first time deb is loaded after reset, so deb is known to reflect the pads.
module vec_debounce #(
  parameter int unsigned W         = 16,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] deb,
  output logic         primed
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     s1;
  logic [W-1:0]     s2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      cnt    <= '0;
      deb    <= '0;
      primed <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      // Any change restarts the stability window; the counter then saturates.
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        deb    <= cand;
        primed <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_encoder.sv
// Turns 16 raw pushbuttons into single-cycle key strobes carrying a 4-bit key index.
module btn_encoder
  import simon_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] pb,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_err,
  output logic                held
);

  key_vec_t   deb;
  logic       primed;
  btn_state_t state;

  vec_debounce #(
    .W         (NUM_KEYS),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (pb),
    .deb    (deb),
    .primed (primed)
  );

  // Press FSM; WAIT_REL leaves only once the debounced pads are known to be all released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_REL;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      key_code  <= '0;
      held      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      if (!en) begin
        state <= WAIT_REL;
        held  <= 1'b0;
      end else begin
        case (state)
          WAIT_REL: begin
            if (deb == '0 && primed) state <= IDLE;
          end
          IDLE: begin
            if (deb != '0) begin
              if (is_onehot(deb)) begin
                key_valid <= 1'b1;
                key_code  <= encode(deb);
              end else begin
                key_err <= 1'b1;
              end
              state <= HELD;
              held  <= 1'b1;
            end
          end
          HELD: begin
            if (deb == '0) begin
              state <= IDLE;
              held  <= 1'b0;
            end
          end
          default: begin
            state <= WAIT_REL;
            held  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/btn_encoder.md
Name: btn_encoder

Overview:
- Reverse direction of the Simon Says one-hot pad decoder. The decoder drives one of 16 LEDs from a 4-bit index; this block turns the player's 16 raw pushbuttons back into a 4-bit key index.
- Synchronises, debounces and edge-qualifies the raw button vector. Emits one single-cycle strobe per clean press, carrying the pressed key code.
- Feeds the game FSM, which compares each code against the stored sequence entry.

Parameters:
- NUM_KEYS, 16, number of buttons; fixed by the pad layout, must equal 2**KEY_W.
- KEY_W, 4, width of the encoded key index.
- DB_CYCLES, 3, consecutive identical synchronised samples required before the debounced vector updates; must be ≥ 1. 3 samples at 100 Hz is about 30 ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  capture enable from the game FSM; high only while the game is waiting for player input.
- pb  in  NUM_KEYS  raw, asynchronous button levels; 1 = pressed.
- key_valid  out  1  one-cycle strobe: a clean single-key press was accepted.
- key_code  out  KEY_W  index of the accepted key; held until the next key_valid.
- key_err  out  1  one-cycle strobe: more than one key was down when the press debounced.
- held  out  1  high while a debounced press is outstanding (FSM in HELD).

Behaviour:
- Reset values:
  - key_valid = 0, key_err = 0, key_code = 0, held = 0.
  - Both synchroniser stages and the candidate and debounced vectors = 0; debounce counter = 0.
  - FSM = WAIT_REL.
- Synchroniser: two flops per bit, s1 <= pb, then s2 <= s1.
- Debounce, one counter for the whole vector:
  - If s2 != cand: cand <= s2 and cnt <= 0.
  - Otherwise, if cnt == DB_CYCLES-1: deb <= cand. Cnt saturates at DB_CYCLES-1.
  - Otherwise: cnt <= cnt+1.
  - Counter width is $clog2(DB_CYCLES)+1.
- Latency: a clean press that is stable from the first sampling edge (edge 1) asserts key_valid on edge DB_CYCLES+4. With DB_CYCLES=3, key_valid asserts on edge 7. Release latency is the same.
- FSM states: WAIT_REL, IDLE, HELD.
  - WAIT_REL: go to IDLE when en=1 and deb==0. Guarantees that a button already down when capture enables is never accepted.
  - IDLE, deb != 0, deb one-hot: key_valid <= 1, key_code <= index of the set bit, go to HELD.
  - IDLE, deb != 0, deb not one-hot: key_err <= 1, key_code unchanged, go to HELD.
  - HELD: held=1. Additional keys pressed while HELD are ignored (no strobe). Go to IDLE when deb==0.
  - In any state, en=0 forces the FSM to WAIT_REL on the next edge. Any strobe already scheduled for that edge is suppressed.
- Strobes are registered and last exactly one cycle. key_valid and key_err are never high together.
- Synchroniser and debounce logic run regardless of en, so deb is always current when en rises.
- One-hot test: deb != 0 and (deb & (deb-1)) == 0. Index encoding is a priority-free OR-reduction (bit i of key_code = OR of deb[k] over all k with bit i of k set); it is valid because the vector is one-hot.
- Glitches shorter than DB_CYCLES samples never reach deb and produce no strobe.
- Reset asserted mid-press: everything returns to reset values immediately. After reset release the key must be released (WAIT_REL) before any strobe can occur.

Decomposition:
- Shared package simon_pkg holds:
  - constants NUM_KEYS=16, KEY_W=4;
  - typedef key_vec_t (logic [NUM_KEYS-1:0]);
  - typedef key_idx_t (logic [KEY_W-1:0]);
  - enum btn_state_t {WAIT_REL, IDLE, HELD}.
- Sub-module vec_debounce: synchroniser plus debounce counter, parameterised on width and DB_CYCLES, output deb.
- btn_encoder contains only the FSM and the encoder.

Test Plan:
- Reset, en=1, pb=16'h0000, then pb=16'h0020 held 10 cycles (DB_CYCLES=3) -> key_valid pulses once on edge 7 with key_code=5; held=1 until 7 edges after release.
- pb=16'h0004 pulsed for 2 cycles, then 0 -> no key_valid, no key_err, held stays 0.
- pb=16'h0101 asserted together -> key_err pulses once, key_valid stays 0, key_code keeps its prior value; release -> back to IDLE; pb=16'h8000 -> key_valid with key_code=15.
- pb=16'h0002 held while en rises -> no strobe until release plus a new press of 16'h0002, then key_valid with key_code=1.
- While HELD on 16'h0008, add 16'h0010 -> no second strobe; release both, then press 16'h0010 -> key_valid with key_code=4.
- Assert rst during HELD, with key still down after rst release -> all outputs 0, no strobe until release and re-press; en=0 mid-debounce -> no strobe.
